// File: rtl/y_window_monitor_pkg.sv
// Shared types and helpers for the y_window_monitor block.
//   state_t      : FSM encoding (IDLE, MEASURE, REPORT)
//   DEF_CNT_W    : default report counter width
//   DEF_WIN_LEN  : default number of y samples per window
//   sat_inc      : increment that sticks at a ceiling value
package y_window_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam int unsigned DEF_CNT_W   = 8;
  localparam int unsigned DEF_WIN_LEN = 16;

  // Returns v+1 when inc is set and v is below vmax, otherwise v unchanged.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] vmax,
                                          input logic        inc);
    if (inc && (v != vmax)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/y_window_monitor_y_sync2.sv
// y_sync2: two-flop synchroniser for the monitored y signal.
// Used by y_window_monitor only when Y_MONITOR_SYNC_EN is defined.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, flops clear to 0
//   i_d  : asynchronous input
//   o_q  : synchronised output, two cycles behind i_d
module y_sync2
  import y_window_monitor_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/y_window_monitor.sv
// y_window_monitor: watches y over a window of WIN_LEN clock edges and
// reports high-cycle count, rising-edge count and a sticky saturation flag
// over a valid/ready handshake.
// Build option: define Y_MONITOR_SYNC_EN to pass y_in through a 2-flop
// synchroniser (y_sync2) before sampling; otherwise y_in is used directly.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   y_in          : monitored signal
//   start         : begin a window (only honoured in IDLE)
//   busy          : high in MEASURE or REPORT
//   rpt_valid     : report available (REPORT state)
//   rpt_ready     : consumer accepts report
//   rpt_high_cnt  : samples with y high
//   rpt_edge_cnt  : 0->1 transitions of sampled y
//   rpt_ovf       : a counter saturated during the window
module y_window_monitor
  import y_window_monitor_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned WIN_LEN = DEF_WIN_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             y_in,
  input  logic             start,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_high_cnt,
  output logic [CNT_W-1:0] rpt_edge_cnt,
  output logic             rpt_ovf
);

  localparam int unsigned      WC_W     = $clog2(WIN_LEN + 1);
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic             r_ovf;
  logic             r_y_prev;
  logic [WC_W-1:0]  r_win_cnt;
  logic             w_y_s;
  logic             w_rise;
  logic             w_last;

`ifdef Y_MONITOR_SYNC_EN
  y_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (y_in),
    .o_q (w_y_s)
  );
`else
  assign w_y_s = y_in;
`endif

  assign w_rise = w_y_s & ~r_y_prev;
  assign w_last = (r_win_cnt == WIN_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    rpt_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = REPORT;
      end
      REPORT: begin
        busy      = 1'b1;
        rpt_valid = 1'b1;
        if (rpt_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // The start-edge sample only seeds y_prev; counting begins on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_high_cnt <= '0;
      r_edge_cnt <= '0;
      r_ovf      <= 1'b0;
      r_y_prev   <= 1'b0;
      r_win_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_high_cnt <= '0;
            r_edge_cnt <= '0;
            r_ovf      <= 1'b0;
            r_win_cnt  <= '0;
            r_y_prev   <= w_y_s;
          end
        end
        MEASURE: begin
          r_high_cnt <= CNT_W'(sat_inc(32'(r_high_cnt), 32'(CNT_MAX), w_y_s));
          r_edge_cnt <= CNT_W'(sat_inc(32'(r_edge_cnt), 32'(CNT_MAX), w_rise));
          if ((w_y_s && (r_high_cnt == CNT_MAX)) ||
              (w_rise && (r_edge_cnt == CNT_MAX)))
            r_ovf <= 1'b1;
          r_y_prev  <= w_y_s;
          r_win_cnt <= r_win_cnt + WC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign rpt_high_cnt = r_high_cnt;
  assign rpt_edge_cnt = r_edge_cnt;
  assign rpt_ovf      = r_ovf;

endmodule
